// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Constants shared between the network-interface packetizer
//               and the router: flit id codes, header field positions,
//               default widths and the packetizer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Default widths for the NoC datapath
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_AXIS       = 4;
    localparam int DEF_LEN_W      = 12;

    // Flit id field: [31:29]
    localparam int ID_W   = 3;
    localparam int ID_LSB = 29;

    // Header fields: len [28:17], dst [16:13], src [12:9], [8:0] zero
    localparam int LEN_LSB = 17;
    localparam int DST_LSB = 13;
    localparam int SRC_LSB = 9;

    // Body/tail flits carry payload in every bit below the id field
    localparam int PL_W = ID_LSB;

    typedef logic [ID_W-1:0] flit_id_t;

    localparam flit_id_t FLIT_HDR  = 3'b001;
    localparam flit_id_t FLIT_BODY = 3'b010;
    localparam flit_id_t FLIT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } tx_state_t;

    // Payload flits are body flits except the final one of the packet
    function automatic flit_id_t payload_id(input logic last_word);
        return last_word ? FLIT_TAIL : FLIT_BODY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ni_packet_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_packet_tx_if
// Description : Bundle of the packetizer's core-side descriptor/payload
//               handshakes and router-side flit port (L_RX/L_DRTS/L_CTS).
//   master : the packetizer (accepts descriptors/payload, drives flits)
//   slave  : the environment (core + router)
//   Signals: cur_addr, req_valid/req_ready/req_dst/req_len,
//            pl_valid/pl_ready/pl_data, TX/RTS/DCTS, busy, pkt_done, err_len
// Revision    : 1.0 - initial release
// ============================================================================
interface ni_packet_tx_if
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AXIS       = DEF_AXIS,
    parameter int LEN_W      = DEF_LEN_W
);

    logic [AXIS-1:0]       cur_addr;

    logic                  req_valid;
    logic                  req_ready;
    logic [AXIS-1:0]       req_dst;
    logic [LEN_W-1:0]      req_len;

    logic                  pl_valid;
    logic                  pl_ready;
    logic [PL_W-1:0]       pl_data;

    logic [DATA_WIDTH-1:0] TX;
    logic                  RTS;
    logic                  DCTS;

    logic                  busy;
    logic                  pkt_done;
    logic                  err_len;

    modport master (
        input  cur_addr,
        input  req_valid, req_dst, req_len,
        output req_ready,
        input  pl_valid, pl_data,
        output pl_ready,
        output TX, RTS,
        input  DCTS,
        output busy, pkt_done, err_len
    );

    modport slave (
        output cur_addr,
        output req_valid, req_dst, req_len,
        input  req_ready,
        output pl_valid, pl_data,
        input  pl_ready,
        input  TX, RTS,
        output DCTS,
        input  busy, pkt_done, err_len
    );

endinterface
`default_nettype wire

// File: rtl/ni_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : ni_packet_tx
// Description : Network-interface packetizer. Accepts a (dst, len)
//               descriptor, then emits a header flit followed by len-1
//               payload flits (last one tagged tail) into a router's local
//               input port. Each flit is a single-cycle RTS strobe and
//               strobes are always separated by at least one idle cycle so
//               the router's CTS can reflect FIFO-full in time.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ni_packet_tx_if.master (descriptor, payload, flit port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module ni_packet_tx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AXIS       = DEF_AXIS,
    parameter int LEN_W      = DEF_LEN_W
) (
    input wire              clk,
    input wire              rst,
    ni_packet_tx_if.master  bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

    tx_state_t             state_q,    state_d;
    logic [LEN_W-1:0]      len_q,      len_d;
    logic [AXIS-1:0]       dst_q,      dst_d;
    logic [LEN_W-1:0]      remain_q,   remain_d;
    logic [DATA_WIDTH-1:0] tx_q,       tx_d;
    logic                  rts_q,      rts_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;
    logic                  busy_q,     busy_d;

    logic                  pl_ready;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] hdr_flit;
    logic [DATA_WIDTH-1:0] pl_flit;

    // The strobe gap is enforced here as well as for the header: a flit may
    // only be issued in a cycle where RTS is low.
    assign pl_ready  = (state_q == ST_PAYLOAD) && bus.DCTS && !rts_q;
    assign last_word = (remain_q == LEN_ONE);

    // Flit assembly
    always_comb begin
        hdr_flit = '0;
        hdr_flit[ID_LSB  +: ID_W]  = FLIT_HDR;
        hdr_flit[LEN_LSB +: LEN_W] = len_q;
        hdr_flit[DST_LSB +: AXIS]  = dst_q;
        hdr_flit[SRC_LSB +: AXIS]  = bus.cur_addr;

        pl_flit = '0;
        pl_flit[ID_LSB +: ID_W] = payload_id(last_word);
        pl_flit[PL_W-1:0]       = bus.pl_data;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        dst_d    = dst_q;
        remain_d = remain_q;
        tx_d     = tx_q;
        rts_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_len >= LEN_MIN) begin
                        len_d    = bus.req_len;
                        dst_d    = bus.req_dst;
                        remain_d = bus.req_len - LEN_ONE;
                        state_d  = ST_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (bus.DCTS && !rts_q) begin
                    tx_d    = hdr_flit;
                    rts_d   = 1'b1;
                    state_d = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (bus.pl_valid && pl_ready) begin
                    tx_d     = pl_flit;
                    rts_d    = 1'b1;
                    // remain_q is at least 1 here, so this never wraps
                    remain_d = remain_q - LEN_ONE;
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered form of (state != IDLE) || RTS
        busy_d = (state_d != ST_IDLE) || rts_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            dst_q    <= '0;
            remain_q <= '0;
            tx_q     <= '0;
            rts_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            dst_q    <= dst_d;
            remain_q <= remain_d;
            tx_q     <= tx_d;
            rts_q    <= rts_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.pl_ready  = pl_ready;
    assign bus.TX        = tx_q;
    assign bus.RTS       = rts_q;
    assign bus.busy      = busy_q;
    assign bus.pkt_done  = done_q;
    assign bus.err_len   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ni_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_packet_tx
// Description : Self-checking bench for ni_packet_tx. A queue of expected
//               flits per packet plus a packet-level activity model drive
//               a per-cycle compare process; directed tests add literal
//               expectations for timing, error pulses and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_packet_tx;

    logic clk;
    logic rst;

    ni_packet_tx_if bus ();

    ni_packet_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Expected flit stream and packet-level model state
    logic [31:0] exp_q[$];
    logic        in_pkt;
    logic        hdr_sent;
    logic [31:0] last_tx;
    logic        err_pend;
    logic        prev_rts;
    logic        prev_dcts;
    int          cyc_n;
    int          acc_cyc;
    int          rts_rel[$];
    logic [31:0] tx_log[$];
    int          done_rel[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr_val(input int len, input int dst, input int src);
        return 32'((1 << 29) + (len << 17) + (dst << 13) + (src << 9));
    endfunction

    function automatic logic [31:0] pl_val(input logic tail, input logic [28:0] d);
        return (tail ? 32'h8000_0000 : 32'h4000_0000) | {3'b000, d};
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] e;
        logic        is_tail;
        cyc_n++;
        if (rst) begin
            exp_q.delete();
            in_pkt    = 1'b0;
            hdr_sent  = 1'b0;
            last_tx   = '0;
            err_pend  = 1'b0;
            prev_rts  = 1'b0;
            prev_dcts = 1'b0;
        end else begin
            if (bus.RTS) begin
                chk("rts_back_to_back", {31'd0, prev_rts}, 32'd0);
                chk("rts_without_cts", {31'd0, prev_dcts}, 32'd1);
                rts_rel.push_back(cyc_n - acc_cyc);
                tx_log.push_back(bus.TX);
                if (bus.pkt_done) done_rel.push_back(cyc_n - acc_cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", bus.TX, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    is_tail = (e[31:29] == 3'b100);
                    chk("tx_flit", bus.TX, e);
                    chk("pkt_done_on_tail", {31'd0, bus.pkt_done}, {31'd0, is_tail});
                    if (e[31:29] == 3'b001) hdr_sent = 1'b1;
                    if (is_tail) begin
                        in_pkt   = 1'b0;
                        hdr_sent = 1'b0;
                    end
                end
                last_tx = bus.TX;
            end else begin
                chk("tx_hold", bus.TX, last_tx);
                chk("pkt_done_idle", {31'd0, bus.pkt_done}, 32'd0);
            end
            chk("busy", {31'd0, bus.busy}, {31'd0, in_pkt || bus.RTS});
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !in_pkt});
            chk("pl_ready", {31'd0, bus.pl_ready},
                {31'd0, in_pkt && hdr_sent && bus.DCTS && !bus.RTS});
            chk("err_len", {31'd0, bus.err_len}, {31'd0, err_pend});

            err_pend = bus.req_valid && bus.req_ready && (bus.req_len < 12'd2);
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc_n;
            if (bus.req_valid && bus.req_ready && bus.req_len >= 12'd2) in_pkt = 1'b1;
            prev_rts  = bus.RTS;
            prev_dcts = bus.DCTS;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Sends one descriptor and feeds its payload. gap_mod>0 drops pl_valid
    // when (cycle % gap_mod)==1; drop_start>=0 lowers DCTS for 5 cycles;
    // abort_n>0 asserts rst while the abort_n-th flit's RTS is high.
    task automatic send_pkt(input int pkt, input int dst, input int len,
                            input int gap_mod, input int drop_start, input int abort_n);
        logic [28:0] data[$];
        int          idx;
        int          cyc;
        int          nrts;
        int          extra;
        logic        acc;
        logic        fire;
        for (int i = 0; i < len - 1; i++) data.push_back(29'(32'h0ABC_0000 + (pkt << 8) + i));
        if (len >= 2) begin
            exp_q.push_back(hdr_val(len, dst, int'(bus.cur_addr)));
            for (int i = 0; i < len - 1; i++) exp_q.push_back(pl_val(i == len - 2, data[i]));
        end

        bus.req_valid = 1'b1;
        bus.req_dst   = 4'(dst);
        bus.req_len   = 12'(len);
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (!acc) begin
            chk("descriptor_accept_timeout", 32'd0, 32'd1);
            return;
        end

        if (len < 2) begin
            @(negedge clk);
            chk("err_len_pulse", {31'd0, bus.err_len}, 32'd1);
            chk("err_no_rts", {31'd0, bus.RTS}, 32'd0);
            @(negedge clk);
            chk("err_len_single", {31'd0, bus.err_len}, 32'd0);
            chk("err_idle_ready", {31'd0, bus.req_ready}, 32'd1);
            @(posedge clk); #1;
            return;
        end

        idx = 0; cyc = 0; nrts = 0; extra = 0;
        while (cyc < 400 && extra < 3) begin
            bus.pl_valid = !(gap_mod > 0 && (cyc % gap_mod) == 1);
            bus.pl_data  = (idx < len - 1) ? data[idx] : 29'h1FFF_FFFF;
            bus.DCTS     = !(drop_start >= 0 && cyc >= drop_start && cyc < drop_start + 5);
            @(negedge clk);
            fire = bus.pl_valid && bus.pl_ready;
            if (bus.RTS) nrts++;
            if (abort_n > 0 && nrts == abort_n) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_TX", bus.TX, 32'd0);
                chk("rst_RTS", {31'd0, bus.RTS}, 32'd0);
                chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
                chk("rst_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
                chk("rst_err_len", {31'd0, bus.err_len}, 32'd0);
                bus.pl_valid = 1'b0;
                bus.DCTS     = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (fire) idx++;
            if (exp_q.size() == 0) extra++;
            cyc++;
        end
        bus.pl_valid = 1'b0;
        bus.DCTS     = 1'b1;
        chk("packet_complete", exp_q.size(), 32'd0);
        chk("pl_words_accepted", idx, len - 1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc_n = 0; acc_cyc = 0;
        in_pkt = 0; hdr_sent = 0; last_tx = 0; err_pend = 0; prev_rts = 0; prev_dcts = 0;
        rst = 1'b1;
        bus.cur_addr  = 4'h0;
        bus.req_valid = 1'b0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = '0;
        bus.DCTS      = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_TX", bus.TX, 32'd0);
        chk("reset_RTS", {31'd0, bus.RTS}, 32'd0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
        chk("reset_err_len", {31'd0, bus.err_len}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic packet: dst=3, len=3, payload 1,2, literal timing
        rts_rel.delete(); tx_log.delete(); done_rel.delete();
        exp_q.push_back(32'h2006_6000);
        exp_q.push_back(32'h4000_0001);
        exp_q.push_back(32'h8000_0002);
        bus.req_valid = 1'b1; bus.req_dst = 4'h3; bus.req_len = 12'd3;
        bus.pl_valid  = 1'b1; bus.pl_data = 29'h1;
        for (int c = 0; c < 10; c++) begin
            logic f;
            @(negedge clk);
            f = bus.pl_valid && bus.pl_ready;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            if (f && bus.pl_data == 29'h1) bus.pl_data = 29'h2;
            else if (f) bus.pl_valid = 1'b0;
        end
        bus.pl_valid = 1'b0;
        chk("t1_rts_count", rts_rel.size(), 32'd3);
        if (rts_rel.size() == 3) begin
            chk("t1_hdr_cycle", rts_rel[0], 32'd2);
            chk("t1_body_cycle", rts_rel[1], 32'd4);
            chk("t1_tail_cycle", rts_rel[2], 32'd6);
            chk("t1_hdr_tx", tx_log[0], 32'h2006_6000);
            chk("t1_body_tx", tx_log[1], 32'h4000_0001);
            chk("t1_tail_tx", tx_log[2], 32'h8000_0002);
        end
        chk("t1_done_count", done_rel.size(), 32'd1);
        if (done_rel.size() == 1) chk("t1_done_cycle", done_rel[0], 32'd6);

        // len=2: header + tail only, non-zero source address
        bus.cur_addr = 4'hA;
        send_pkt(2, 5, 2, 0, -1, 0);

        // Rejected descriptors, then a normal one
        send_pkt(3, 7, 1, 0, -1, 0);
        send_pkt(4, 7, 0, 0, -1, 0);
        send_pkt(5, 9, 4, 0, -1, 0);

        // CTS dropped for 5 cycles mid-body
        send_pkt(6, 2, 6, 0, 7, 0);

        // Payload valid gaps
        send_pkt(7, 12, 5, 3, -1, 0);

        // Reset during the second body flit of a len=6 packet, then a fresh packet
        send_pkt(8, 4, 6, 0, -1, 3);
        @(posedge clk); #1;
        rts_rel.delete(); tx_log.delete(); done_rel.delete();
        send_pkt(9, 6, 3, 0, -1, 0);
        chk("post_reset_hdr_first", (tx_log.size() > 0) ? tx_log[0] : 32'd0, hdr_val(3, 6, 10));

        repeat (3) @(posedge clk);
        chk("final_exp_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ni_packet_tx.md
# ni_packet_tx

Network-interface packetizer that drives a router's Local input port (`L_RX`/`L_DRTS`/`L_CTS`) from a core-side request/payload stream. It takes a packet descriptor (destination, length) plus payload words and emits a header flit, then body flits, then a tail flit. Each flit is presented with a single-cycle RTS strobe under CTS flow control. It is the transmitting end of the router's input-FIFO handshake and sits between a traffic generator or core and one router's `L_*` port.

## Interface
- `DATA_WIDTH`, 32: flit width.
- `AXIS`, 4: node address width.
- `LEN_W`, 12: packet length field width.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cur_addr` in AXIS: this node's address, placed in the header source field.
- `req_valid` in 1: packet descriptor valid.
- `req_ready` out 1: descriptor accepted when high together with `req_valid`.
- `req_dst` in AXIS: destination address.
- `req_len` in LEN_W: total flits including header and tail; legal range 2..4095.
- `pl_valid` in 1: payload word valid.
- `pl_ready` out 1: payload word consumed this edge.
- `pl_data` in 29: payload word, placed in flit bits [28:0].
- `TX` out DATA_WIDTH: flit to the router's `L_RX`.
- `RTS` out 1: flit strobe to the router's `L_DRTS`.
- `DCTS` in 1: router's `L_CTS`; high means the input FIFO can accept a flit.
- `busy` out 1: packet in progress.
- `pkt_done` out 1: one-cycle pulse, coincident with the tail flit's RTS.
- `err_len` out 1: one-cycle pulse when a descriptor with `req_len` < 2 is rejected.

## Operation
- Flit format:
  - [31:29] flit id: header 3'b001, body 3'b010, tail 3'b100.
  - Header [28:17] = `req_len`, [16:13] = `req_dst`, [12:9] = `cur_addr`, [8:0] = 0.
  - Body and tail [28:0] = payload.
- Payload word count per packet = `req_len` − 1, with no separate header payload.
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: `req_ready`=1. On `req_valid`:
    - If `req_len` ≥ 2: latch dst and len, load `remaining` = len−1, go to HDR.
    - Otherwise: pulse `err_len` the next cycle and stay in IDLE.
  - HDR: the header is issued when `DCTS`=1 and `RTS`=0, then go to PAYLOAD.
  - PAYLOAD: `pl_ready` = `DCTS` && !`RTS` (combinational).
    - On `pl_valid` && `pl_ready`, issue a flit with id = tail if `remaining`==1, else body.
    - Each issue decrements `remaining`; issuing the tail returns the FSM to IDLE.
- Issue means that on the next edge `TX` is loaded and `RTS` goes to 1 for exactly one cycle.
- `RTS` is never high on two consecutive cycles, so the router's CTS has one cycle to reflect FIFO-full.
- `TX` holds the last flit when `RTS`=0.
- `busy` = (state ≠ IDLE) || `RTS`.
- No new descriptor is accepted until the FSM returns to IDLE. `req_ready` may be high in the same cycle as the tail's `RTS`.
- Reset mid-packet: the packet is truncated, with no tail sent. All state clears immediately.

## Timing
- Reset values: `TX`=0, `RTS`=0, `req_ready`=1 (IDLE), `pl_ready`=0, `busy`=0, `pkt_done`=0, `err_len`=0.
- All outputs are registered except `req_ready` and `pl_ready`, which decode from state, `DCTS` and `RTS`.
- Header latency: descriptor accepted at edge 0 and `DCTS`=1 in cycle 1 → header `RTS` in cycle 2.
- Peak throughput is one flit per 2 cycles. A packet of length L with no stalls takes 2L cycles from the first header `RTS` to the cycle after the tail.
- `DCTS`=0 stalls issue indefinitely; state and `remaining` hold.
- `pl_valid`=0 in PAYLOAD stalls without issuing.
- `remaining` is LEN_W bits and never underflows; `req_len`=2 produces header + tail only.

## Structure
- Shared package `noc_pkg` holds:
  - Flit id constants: FLIT_HDR, FLIT_BODY, FLIT_TAIL.
  - Field bit positions: ID_LSB=29, LEN_LSB=17, DST_LSB=13, SRC_LSB=9.
  - `DATA_WIDTH` and `AXIS` defaults.
- The router's length/address extraction uses the same package constants.
- Single flat module with no sub-module; FSM, counter and output register are all in `ni_packet_tx`.

## Test plan
- Descriptor dst=4'h3, len=3 with payloads 29'h1, 29'h2 and `DCTS` tied 1, `cur_addr`=4'h0:
  - `TX` sequence 32'h2006_6000, 32'h4000_0001, 32'h8000_0002.
  - `RTS` high in cycles 2, 4, 6.
  - `pkt_done` high in cycle 6.
- len=2 → header then tail only (id 3'b100); `pl_ready` accepts exactly one word.
- len=1 or len=0 → `err_len` pulses once, no `RTS`, FSM stays IDLE, and the next valid descriptor is accepted normally.
- `DCTS` dropped for 5 cycles mid-body → no `RTS` and `pl_ready`=0 during the drop; sequence resumes with no lost or duplicated flit.
- `pl_valid` gaps during PAYLOAD → flits are issued only on accepted words; `remaining` is decremented only on issue.
- `rst` asserted during the second body flit of a len=6 packet → all outputs at reset values immediately. A fresh len=3 packet then sends a header first.
